exu_wbck_arb: RTL and testbench

Writeback arbiter directly downstream of the ALU execution stage. It merges the ALU writeback channel (single-cycle results) and the LSU long-pipe writeback channel (load data) onto the single register-file write port. LSU has fixed priority, bounded by an ALU anti-starvation counter. A 1-entry skid buffer holds an ALU result that loses arbitration, and the register-file write is registered (1-cycle latency).

---
 rtl/exu_wbck_arb_if.sv | 32 +++
 rtl/exu_wbck_arb.sv | 85 ++++++++
 tb/tb_exu_wbck_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/exu_wbck_arb_if.sv
// Writeback bundle between the ALU/LSU producers, the arbiter and the register file.
interface exu_wbck_arb_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5
);
    logic                   alu_wbck_i_valid;
    logic                   alu_wbck_i_ready;
    logic [XLEN-1:0]        alu_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;
    logic                   lsu_wbck_i_valid;
    logic                   lsu_wbck_i_ready;
    logic [XLEN-1:0]        lsu_wbck_i_wdat;
    logic [RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx;
    logic                   rf_wbck_o_ena;
    logic [XLEN-1:0]        rf_wbck_o_wdat;
    logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx;
    logic                   wbck_o_busy;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        input  alu_wbck_i_ready, lsu_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_o_busy
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
        output alu_wbck_i_ready, lsu_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_o_busy
    );
endinterface

// File: rtl/exu_wbck_arb.sv
// Merges ALU and LSU writebacks onto one register-file write port: LSU priority,
// bounded by an ALU anti-starvation counter, with a 1-entry ALU skid buffer.
module exu_wbck_arb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    exu_wbck_arb_if.slave   wb
);
    localparam int unsigned CNT_W = 4;

    logic                   buf_vld;
    logic [XLEN-1:0]        buf_wdat;
    logic [RFIDX_WIDTH-1:0] buf_rdidx;
    logic [CNT_W-1:0]       starve_cnt;

    logic                   alu_cand_vld;
    logic [XLEN-1:0]        alu_cand_wdat;
    logic [RFIDX_WIDTH-1:0] alu_cand_rdidx;
    logic                   force_alu;
    logic                   grant_lsu;
    logic                   grant_alu;
    logic [XLEN-1:0]        gnt_wdat;
    logic [RFIDX_WIDTH-1:0] gnt_rdidx;

    // Candidate selection and grant
    always_comb begin
        alu_cand_vld   = buf_vld | wb.alu_wbck_i_valid;
        alu_cand_wdat  = buf_vld ? buf_wdat  : wb.alu_wbck_i_wdat;
        alu_cand_rdidx = buf_vld ? buf_rdidx : wb.alu_wbck_i_rdidx;
        force_alu      = alu_cand_vld & (starve_cnt == CNT_W'(STARVE_MAX));
        grant_lsu      = wb.lsu_wbck_i_valid & ~force_alu;
        grant_alu      = alu_cand_vld & ~grant_lsu;
        gnt_wdat       = grant_lsu ? wb.lsu_wbck_i_wdat  : alu_cand_wdat;
        gnt_rdidx      = grant_lsu ? wb.lsu_wbck_i_rdidx : alu_cand_rdidx;
    end

    // Ready only depends on buffer occupancy and the starvation force, never on the grant.
    assign wb.alu_wbck_i_ready = ~buf_vld;
    assign wb.lsu_wbck_i_ready = ~force_alu;
    assign wb.wbck_o_busy      = buf_vld;

    // Skid buffer: capture a losing direct ALU input, drain on ALU grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_vld   <= 1'b0;
            buf_wdat  <= '0;
            buf_rdidx <= '0;
        end else if (wb.alu_wbck_i_valid & ~buf_vld & ~grant_alu) begin
            buf_vld   <= 1'b1;
            buf_wdat  <= wb.alu_wbck_i_wdat;
            buf_rdidx <= wb.alu_wbck_i_rdidx;
        end else if (buf_vld & grant_alu) begin
            buf_vld   <= 1'b0;
        end
    end

    // Consecutive ALU losses, saturating at STARVE_MAX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_alu | ~alu_cand_vld) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Registered write port; x0 writes are consumed but never enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb.rf_wbck_o_ena   <= 1'b0;
            wb.rf_wbck_o_wdat  <= '0;
            wb.rf_wbck_o_rdidx <= '0;
        end else begin
            wb.rf_wbck_o_ena <= (grant_alu | grant_lsu) & (gnt_rdidx != '0);
            if (grant_alu | grant_lsu) begin
                wb.rf_wbck_o_wdat  <= gnt_wdat;
                wb.rf_wbck_o_rdidx <= gnt_rdidx;
            end
        end
    end
endmodule

// File: tb/tb_exu_wbck_arb.sv
// Table-driven check of the writeback arbiter with a write scoreboard.
module tb_exu_wbck_arb;
    logic clk = 1'b0;
    logic rst_n;

    exu_wbck_arb_if #(.XLEN(32), .RFIDX_WIDTH(5)) wb ();

    exu_wbck_arb #(.XLEN(32), .RFIDX_WIDTH(5), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic        chk_c;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_busy;
        logic        e_ena;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        logic        ena;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic rst, logic av, logic [4:0] ard, logic [31:0] awd,
                                logic lv, logic [4:0] lrd, logic [31:0] lwd,
                                logic chk_c, logic e_ardy, logic e_lrdy, logic e_busy,
                                logic e_ena, logic [4:0] e_rd, logic [31:0] e_wd);
        vec_t v;
        v = '{rst, av, ard, awd, lv, lrd, lwd, chk_c, e_ardy, e_lrdy, e_busy, e_ena, e_rd, e_wd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        logic found;
        int   n_lsu;

        rst_n = 1'b0;
        wb.alu_wbck_i_valid = 1'b0; wb.alu_wbck_i_wdat = '0; wb.alu_wbck_i_rdidx = '0;
        wb.lsu_wbck_i_valid = 1'b0; wb.lsu_wbck_i_wdat = '0; wb.lsu_wbck_i_rdidx = '0;

        //           rst av ard awd           lv lrd lwd           chk ardy lrdy busy ena rd  wd
        // reset held with ALU valid, then first write
        vt.push_back(mk(0, 1, 5, 32'h11,       0, 0,  0,            0, 1, 1, 0,  0, 0,  0));
        vt.push_back(mk(0, 1, 5, 32'h11,       0, 0,  0,            1, 1, 1, 0,  0, 0,  0));
        vt.push_back(mk(1, 1, 5, 32'h11,       0, 0,  0,            1, 1, 1, 0,  1, 5,  32'h11));
        // simultaneous: LSU first, ALU drained from buffer
        vt.push_back(mk(1, 1, 3, 32'hAA,       1, 4,  32'hBB,       1, 1, 1, 0,  1, 4,  32'hBB));
        vt.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 0, 1, 1,  1, 3,  32'hAA));
        vt.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 1, 1, 0,  0, 0,  0));
        // continuous LSU starves ALU for three cycles, then ALU is forced
        vt.push_back(mk(1, 1, 7, 32'h77,       1, 10, 32'h100,      1, 1, 1, 0,  1, 10, 32'h100));
        vt.push_back(mk(1, 0, 0, 0,            1, 11, 32'h101,      1, 0, 1, 1,  1, 11, 32'h101));
        vt.push_back(mk(1, 0, 0, 0,            1, 12, 32'h102,      1, 0, 1, 1,  1, 12, 32'h102));
        vt.push_back(mk(1, 0, 0, 0,            1, 13, 32'h103,      1, 0, 0, 1,  1, 7,  32'h77));
        vt.push_back(mk(1, 0, 0, 0,            1, 13, 32'h103,      1, 1, 1, 0,  1, 13, 32'h103));
        // x0 write consumed without enable, no stall afterwards
        vt.push_back(mk(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0,            1, 1, 1, 0,  0, 0,  0));
        vt.push_back(mk(1, 1, 2, 32'h22,       0, 0,  0,            1, 1, 1, 0,  1, 2,  32'h22));
        // buffer filled, then reset discards it and the pending counter
        vt.push_back(mk(1, 1, 6, 32'h66,       1, 9,  32'h99,       1, 1, 1, 0,  1, 9,  32'h99));
        vt.push_back(mk(0, 0, 0, 0,            0, 0,  0,            1, 0, 1, 1,  0, 0,  0));
        vt.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 1, 1, 0,  0, 0,  0));
        // counter restarted from zero: still three LSU wins before forcing
        vt.push_back(mk(1, 1, 8, 32'h88,       1, 14, 32'hE0,       1, 1, 1, 0,  1, 14, 32'hE0));
        vt.push_back(mk(1, 0, 0, 0,            1, 15, 32'hE1,       1, 0, 1, 1,  1, 15, 32'hE1));
        vt.push_back(mk(1, 0, 0, 0,            1, 16, 32'hE2,       1, 0, 1, 1,  1, 16, 32'hE2));
        vt.push_back(mk(1, 0, 0, 0,            1, 17, 32'hE3,       1, 0, 0, 1,  1, 8,  32'h88));
        vt.push_back(mk(1, 0, 0, 0,            1, 17, 32'hE3,       1, 1, 1, 0,  1, 17, 32'hE3));
        // back-to-back ALU writes rd 1..8
        for (int i = 1; i <= 8; i++)
            vt.push_back(mk(1, 1, 5'(i), 32'h100 + 32'(i), 0, 0, 0, 1, 1, 1, 0, 1, 5'(i), 32'h100 + 32'(i)));
        vt.push_back(mk(1, 0, 0, 0,            0, 0,  0,            1, 1, 1, 0,  0, 0,  0));

        foreach (vt[i]) begin
            @(negedge clk);
            rst_n               = vt[i].rst;
            wb.alu_wbck_i_valid = vt[i].av;
            wb.alu_wbck_i_rdidx = vt[i].ard;
            wb.alu_wbck_i_wdat  = vt[i].awd;
            wb.lsu_wbck_i_valid = vt[i].lv;
            wb.lsu_wbck_i_rdidx = vt[i].lrd;
            wb.lsu_wbck_i_wdat  = vt[i].lwd;
            #1;
            if (vt[i].chk_c) begin
                chk($sformatf("alu_ready[%0d]", i), 32'(wb.alu_wbck_i_ready), 32'(vt[i].e_ardy));
                chk($sformatf("lsu_ready[%0d]", i), 32'(wb.lsu_wbck_i_ready), 32'(vt[i].e_lrdy));
                chk($sformatf("busy[%0d]", i),      32'(wb.wbck_o_busy),      32'(vt[i].e_busy));
            end
            sb.push_back('{vt[i].e_ena, vt[i].e_rd, vt[i].e_wd});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("ena[%0d]", i), 32'(wb.rf_wbck_o_ena), 32'(e.ena));
            if (e.ena) begin
                chk($sformatf("rdidx[%0d]", i), 32'(wb.rf_wbck_o_rdidx), 32'(e.rd));
                chk($sformatf("wdat[%0d]", i),  wb.rf_wbck_o_wdat,       e.wd);
            end
        end

        // idle: payload holds the last write, enable stays low
        @(negedge clk);
        @(posedge clk); #1;
        chk("hold_ena",   32'(wb.rf_wbck_o_ena),   32'd0);
        chk("hold_rdidx", 32'(wb.rf_wbck_o_rdidx), 32'd8);
        chk("hold_wdat",  wb.rf_wbck_o_wdat,       32'h108);

        // bounded wait for a forced ALU write under continuous LSU traffic
        @(negedge clk);
        wb.alu_wbck_i_valid = 1'b1; wb.alu_wbck_i_rdidx = 5'd20; wb.alu_wbck_i_wdat = 32'h1234;
        wb.lsu_wbck_i_valid = 1'b1; wb.lsu_wbck_i_rdidx = 5'd21; wb.lsu_wbck_i_wdat = 32'h500;
        found = 1'b0;
        n_lsu = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(posedge clk); #1;
            if (c == 0) wb.alu_wbck_i_valid = 1'b0;
            if (wb.rf_wbck_o_ena) begin
                if (wb.rf_wbck_o_rdidx == 5'd20) found = 1'b1;
                else n_lsu++;
            end
        end
        chk("force_seen",    32'(found), 32'd1);
        chk("force_lsu_cnt", 32'(n_lsu), 32'd3);
        chk("force_wdat",    wb.rf_wbck_o_wdat, 32'h1234);
        wb.lsu_wbck_i_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
